// File: rtl/tmds_pkg.sv
// Shared TMDS serializer types, constants and the phase-to-bit-pair selector.
package tmds_pkg;

  localparam int unsigned TMDS_WORD_W    = 10;
  localparam int unsigned TMDS_SER_RATIO = 5;

  typedef logic [TMDS_WORD_W-1:0] tmds_char_t;

  localparam tmds_char_t TMDS_CLK_PATTERN = 10'b11111_00000;

  // One state per SerialClk cycle of the pixel period; state k sends pair k.
  typedef enum logic [2:0] {
    PH_0 = 3'd0,
    PH_1 = 3'd1,
    PH_2 = 3'd2,
    PH_3 = 3'd3,
    PH_4 = 3'd4
  } phase_e;

  // Returns {bit 2k+1, bit 2k}: bit 2k is sent first (rising half).
  function automatic logic [1:0] pair_sel(input tmds_char_t w, input phase_e ph);
    logic [1:0] pair;
    pair = '0;
    case (ph)
      PH_0:    pair = w[1:0];
      PH_1:    pair = w[3:2];
      PH_2:    pair = w[5:4];
      PH_3:    pair = w[7:6];
      PH_4:    pair = w[9:8];
      default: pair = '0;
    endcase
    return pair;
  endfunction

endpackage

// File: rtl/tmds_output_serdes_oddr.sv
// Behavioural DDR output register: D1 drives the high half of SerialClk,
// D2 (captured on the rising edge) drives the following low half.
module tmds_oddr (
  input  logic D1,
  input  logic D2,
  input  logic SerialClk,
  input  logic RstB,
  output logic Q
);

  logic rise_q, rise_d;
  logic hold_q, hold_d;
  logic fall_q, fall_d;

  always_comb begin
    rise_d = D1;
    hold_d = D2;
    if (!RstB) begin
      rise_d = '0;
      hold_d = '0;
    end
  end

  always_ff @(posedge SerialClk) begin
    rise_q <= rise_d;
    hold_q <= hold_d;
  end

  // No reset here: it reloads the already-cleared hold register.
  always_comb fall_d = hold_q;

  always_ff @(negedge SerialClk) begin
    fall_q <= fall_d;
  end

  assign Q = SerialClk ? rise_q : fall_q;

endmodule

// File: rtl/tmds_output_serdes.sv
// Single-lane 10:1 TMDS serializer, LSB first, DDR on the 5x SerialClk.
// PixelClk is only sampled as data to find the character boundary.
module tmds_output_serdes
  import tmds_pkg::*;
#(
  parameter int unsigned WORD_W = 10,
  parameter int unsigned RATIO  = 5
) (
  input  logic              SerialClk,
  input  logic              RstB,
  input  logic              PixelClk,
  input  logic [WORD_W-1:0] DataOut,
  output logic              DataOut_P,
  output logic              DataOut_N
);

  logic [2:0] sync_q, sync_d;
  tmds_char_t word_q, word_d;
  phase_e     phase_q, phase_d;
  logic       load;
  logic [1:0] pair;
  logic       ser;

  // sync bit0 = p1, bit1 = p2, bit2 = p3
  assign load = sync_q[1] & ~sync_q[2];
  assign pair = pair_sel(word_q, phase_q);

  always_comb begin
    sync_d  = {sync_q[1:0], PixelClk};
    word_d  = word_q;
    phase_d = (phase_q == phase_e'(RATIO - 1)) ? PH_0 : phase_e'(phase_q + 3'd1);
    if (load) begin
      word_d  = DataOut;
      phase_d = PH_0;
    end
    if (!RstB) begin
      sync_d  = '0;
      word_d  = '0;
      phase_d = PH_0;
    end
  end

  always_ff @(posedge SerialClk) begin
    sync_q  <= sync_d;
    word_q  <= word_d;
    phase_q <= phase_d;
  end

  // Pair is chosen from the pre-update phase, so a realigning load still
  // emits the old word's current pair on that edge.
  tmds_oddr u_oddr (
    .D1        (pair[0]),
    .D2        (pair[1]),
    .SerialClk (SerialClk),
    .RstB      (RstB),
    .Q         (ser)
  );

  assign DataOut_P = ser;
  assign DataOut_N = ~ser;

endmodule

// File: tb/tb_tmds_output_serdes.sv
// Scoreboard bench: every PixelClk rise queues the expected half-bit stream,
// a monitor samples the line each half SerialClk period and compares.
module tb_tmds_output_serdes;

  logic       SerialClk;
  logic       RstB;
  logic       PixelClk;
  logic [9:0] DataOut;
  logic       DataOut_P;
  logic       DataOut_N;

  typedef struct {
    int   idx;
    logic val;
  } exp_t;

  exp_t exp_q[$];
  int   rcnt      = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  logic pclk_prev = 1'b0;

  tmds_output_serdes #(.WORD_W(10), .RATIO(5)) dut (
    .SerialClk (SerialClk),
    .RstB      (RstB),
    .PixelClk  (PixelClk),
    .DataOut   (DataOut),
    .DataOut_P (DataOut_P),
    .DataOut_N (DataOut_N)
  );

  initial SerialClk = 1'b0;
  always #5 SerialClk = ~SerialClk;

  // Half-bit index h: 2*n is the high half after rising edge n, 2*n+1 the low half.
  task automatic check(input int h);
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].idx < h) begin
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_sample idx=%0d: never compared, required %b", e.idx, e.val);
    end
    if (exp_q.size() > 0 && exp_q[0].idx == h) begin
      e = exp_q.pop_front();
      n_checks++;
      if (DataOut_P !== e.val) begin
        n_fail++;
        $display("FAIL DataOut_P idx=%0d t=%0t: got %b, required %b", h, $time, DataOut_P, e.val);
      end
      n_checks++;
      if (DataOut_N !== ~e.val) begin
        n_fail++;
        $display("FAIL DataOut_N idx=%0d t=%0t: got %b, required %b", h, $time, DataOut_N, ~e.val);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge SerialClk);
      rcnt++;
      #2 check(2 * rcnt);
      @(negedge SerialClk);
      #2 check(2 * rcnt + 1);
    end
  end

  // Replaces any queued future expectations (truncated old word) with reps
  // copies of the new character starting at half-bit index start.
  task automatic push_word(input int start, input logic [9:0] d, input int reps);
    exp_t e;
    while (exp_q.size() > 0 && exp_q[$].idx >= start) void'(exp_q.pop_back());
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < 10; i++) begin
        e.idx = start + 10 * r + i;
        e.val = d[i];
        exp_q.push_back(e);
      end
    end
  endtask

  // PixelClk rise between edges R and R+1 -> load at R+3 -> bit0 at high half of R+4.
  task automatic cyc(input logic p, input logic [9:0] d);
    @(negedge SerialClk);
    if (p && !pclk_prev && RstB) push_word(2 * (rcnt + 4), d, 4);
    PixelClk  = p;
    DataOut   = d;
    pclk_prev = p;
  endtask

  task automatic period(input logic [9:0] d, input int len);
    for (int c = 0; c < len; c++) cyc(c < 2, d);
  endtask

  initial begin
    exp_t e;
    RstB     = 1'b0;
    PixelClk = 1'b0;
    DataOut  = 10'h155;
    // Line is 0 from the first reset edge until the first post-reset load.
    for (int i = 2; i <= 800; i++) begin
      e.idx = i;
      e.val = 1'b0;
      exp_q.push_back(e);
    end

    for (int c = 0; c < 100; c++) cyc((c < 90) && (c % 5 < 2), 10'h155);
    RstB = 1'b1;
    for (int c = 0; c < 4; c++) cyc(1'b0, 10'h000);

    // Latency: single rise with 0x001, then no reference -> word repeats.
    cyc(1'b1, 10'h001);
    for (int c = 0; c < 3; c++) cyc(1'b1, 10'h001);
    for (int c = 0; c < 16; c++) cyc(1'b0, 10'h001);

    // Clock-channel pattern, then data pattern.
    for (int k = 0; k < 6; k++) period(10'b11111_00000, 5);
    for (int k = 0; k < 5; k++) period(10'h2DB, 5);

    // Realignment: reference arrives 2 cycles early.
    period(10'h2DB, 3);
    for (int k = 0; k < 4; k++) period(10'h2DB, 5);

    // Reference stops after this rise.
    cyc(1'b1, 10'h2DB);
    cyc(1'b1, 10'h2DB);
    for (int c = 0; c < 25; c++) cyc(1'b0, 10'h2DB);

    for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(posedge SerialClk);
    #4;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
